// File: rtl/boot_load_sequencer.sv
// Boot loader: parses a little-endian {addr, len} header from a byte stream, writes the image
// into IMEM/DMEM word-by-word while holding the CPU in reset, then releases it.
module boot_load_sequencer #(
    parameter int unsigned MEM_ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int unsigned RST_HOLD       = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_valid_i,
    output logic                      rx_ready_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]               mem_din_o,
    output logic                      mem_we_o,
    output logic                      cpu_rst_o,
    output logic                      done_o,
    output logic                      error_o
);

    typedef enum logic [2:0] {
        StHdrAddr, StHdrLen, StCheck, StData, StRelease, StRun, StError
    } state_e;

    localparam logic [32:0] MemDepth = 33'(1) << MEM_ADDR_WIDTH;

    state_e                    state_q, state_d;
    logic [1:0]                byte_cnt_q, byte_cnt_d;
    logic [23:0]               shreg_q, shreg_d;
    logic [31:0]               load_addr_q, load_addr_d;
    logic [31:0]               load_len_q, load_len_d;
    logic [MEM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [31:0]               rem_q, rem_d;
    logic [31:0]               hold_cnt_q, hold_cnt_d;
    logic                      rx_ready_q, rx_ready_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]               mem_din_q, mem_din_d;
    logic                      mem_we_q, mem_we_d;
    logic                      cpu_rst_q, cpu_rst_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;

    logic        fire;
    logic        last_byte;
    logic [31:0] word;
    logic [29:0] word_off;
    logic [32:0] span;
    logic        hdr_bad;

    assign fire      = rx_valid_i & rx_ready_q;
    assign last_byte = fire && (byte_cnt_q == 2'd3);
    assign word      = {rx_data_i, shreg_q};

    // Offset is only meaningful when the address is aligned; misalignment errors out anyway.
    assign word_off = load_addr_q[31:2] - BASE_ADDR[31:2];
    assign span     = {3'b000, word_off} + {1'b0, load_len_q};
    assign hdr_bad  = (load_addr_q[1:0] != 2'b00) || (load_addr_q < BASE_ADDR) ||
                      (span > MemDepth);

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        shreg_d     = shreg_q;
        load_addr_d = load_addr_q;
        load_len_d  = load_len_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        hold_cnt_d  = hold_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = 1'b0;

        if (fire) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shreg_d    = {rx_data_i, shreg_q[23:8]};
        end

        case (state_q)
            StHdrAddr: begin
                if (last_byte) begin
                    load_addr_d = word;
                    state_d     = StHdrLen;
                end
            end
            StHdrLen: begin
                if (last_byte) begin
                    load_len_d = word;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                hold_cnt_d = '0;
                if (hdr_bad) begin
                    state_d = StError;
                end else if (load_len_q == 32'd0) begin
                    state_d = StRelease;
                end else begin
                    state_d = StData;
                    ptr_d   = word_off[MEM_ADDR_WIDTH-1:0];
                    rem_d   = load_len_q;
                end
            end
            StData: begin
                if (last_byte) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = ptr_q;
                    mem_din_d  = word;
                end
                // Pointer bookkeeping happens in the write cycle itself.
                if (mem_we_q) begin
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        state_d    = StRelease;
                        hold_cnt_d = '0;
                    end
                end
            end
            StRelease: begin
                if (hold_cnt_q == 32'(RST_HOLD - 1)) begin
                    state_d = StRun;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            StRun, StError: ;
            default: state_d = StHdrAddr;
        endcase

        rx_ready_d = (state_d == StHdrAddr) || (state_d == StHdrLen) || (state_d == StData);
        cpu_rst_d  = (state_d != StRun);
        done_d     = (state_d == StRun);
        error_d    = (state_d == StError);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StHdrAddr;
            byte_cnt_q  <= '0;
            shreg_q     <= '0;
            load_addr_q <= '0;
            load_len_q  <= '0;
            ptr_q       <= '0;
            rem_q       <= '0;
            hold_cnt_q  <= '0;
            rx_ready_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shreg_q     <= shreg_d;
            load_addr_q <= load_addr_d;
            load_len_q  <= load_len_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            hold_cnt_q  <= hold_cnt_d;
            rx_ready_q  <= rx_ready_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign rx_ready_o = rx_ready_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_din_o  = mem_din_q;
    assign mem_we_o   = mem_we_q;
    assign cpu_rst_o  = cpu_rst_q;
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule
